// File: rtl/pmu_ahb_slave.sv
// PMU register block on an AHB-lite slave port: event counters, overflow and quota IRQs.
// Optional quota accounting is enabled by defining PMU_QUOTA_EN.
module pmu_ahb_slave #(
  parameter logic [31:0] haddr      = 32'h80100000,
  parameter logic [31:0] hmask      = 32'hfff,
  parameter int          REG_WIDTH  = 32,
  parameter int          N_REGS     = 47,
  parameter int          N_COUNTERS = 24,
  parameter int          N_SOC_EV   = 32
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                hsel_i,
  input  logic                hreadyi_i,
  input  logic [31:0]         haddr_i,
  input  logic                hwrite_i,
  input  logic [1:0]          htrans_i,
  input  logic [2:0]          hsize_i,
  input  logic [2:0]          hburst_i,
  input  logic [31:0]         hwdata_i,
  input  logic [3:0]          hprot_i,
  input  logic                hmastlock_i,
  output logic                hreadyo_o,
  output logic [1:0]          hresp_o,
  output logic [31:0]         hrdata_o,
  input  logic [N_SOC_EV-1:0] events_i,
  output logic                intr_overflow_o,
  output logic                intr_quota_o,
  output logic                intr_MCCU_o,
  output logic                intr_RDC_o
);

  localparam logic [31:0] BASE = haddr & ~hmask;
  localparam int CW = $clog2(N_COUNTERS);
  localparam logic [31:0] I_OMASK = 32'(N_COUNTERS + 1);
  localparam logic [31:0] I_OST   = 32'(N_COUNTERS + 2);
  localparam logic [31:0] I_QMASK = 32'(N_COUNTERS + 3);
  localparam logic [31:0] I_QLIM  = 32'(N_COUNTERS + 4);
  localparam logic [31:0] I_QACC  = 32'(N_COUNTERS + 5);

  typedef logic [REG_WIDTH-1:0] reg_t;

  logic        acc_w;
  logic        dvalid_q;
  logic        dwrite_q;
  logic        dinreg_q;
  logic [31:0] didx_q;

  logic                  en_q, en_d;
  reg_t                  cnt_q [N_COUNTERS];
  reg_t                  cnt_d [N_COUNTERS];
  logic [N_COUNTERS-1:0] wrap_w;
  reg_t                  omask_q, omask_d;
  logic [N_COUNTERS-1:0] ost_q, ost_d;
  logic                  intr_ovf_q;

  logic        wr_w, rd_w, softrst_w;
  logic [31:0] csel_w;
  reg_t        rdata_w;

  assign acc_w = hsel_i & hreadyi_i & htrans_i[1];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      dvalid_q <= 1'b0;
      dwrite_q <= 1'b0;
      dinreg_q <= 1'b0;
      didx_q   <= '0;
    end else begin
      dvalid_q <= acc_w;
      if (acc_w) begin
        dwrite_q <= hwrite_i;
        dinreg_q <= (haddr_i & ~hmask) == BASE;
        didx_q   <= (haddr_i & hmask) >> 2;
      end
    end
  end

  assign wr_w = dvalid_q & dwrite_q & dinreg_q
              & (didx_q < 32'(N_REGS));
  assign rd_w = dvalid_q & ~dwrite_q & dinreg_q
              & (didx_q < 32'(N_REGS));
  assign softrst_w = wr_w & (didx_q == '0) & hwdata_i[1];
  assign csel_w = didx_q - 32'd1;

  always_comb begin
    en_d    = en_q;
    omask_d = omask_q;
    if (wr_w && didx_q == '0) en_d = hwdata_i[0];
    if (wr_w && didx_q == I_OMASK) omask_d = hwdata_i;
  end

  // Priority per counter: soft reset, then bus write, then event increment.
  always_comb begin
    wrap_w = '0;
    for (int i = 0; i < N_COUNTERS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (softrst_w) begin
        cnt_d[i] = '0;
      end else if (wr_w && didx_q == 32'(i + 1)) begin
        cnt_d[i] = hwdata_i;
      end else if (en_q && events_i[i]) begin
        cnt_d[i]  = cnt_q[i] + reg_t'(1);
        wrap_w[i] = &cnt_q[i];
      end
    end
  end

  // A wrap in the same cycle as its W1C wins so no overflow is lost.
  always_comb begin
    ost_d = ost_q;
    if (wr_w && didx_q == I_OST)
      ost_d = ost_q & ~hwdata_i[N_COUNTERS-1:0];
    ost_d = ost_d | wrap_w;
    if (softrst_w) ost_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      en_q       <= 1'b0;
      omask_q    <= '0;
      ost_q      <= '0;
      intr_ovf_q <= 1'b0;
      for (int i = 0; i < N_COUNTERS; i++)
        cnt_q[i] <= '0;
    end else begin
      en_q       <= en_d;
      omask_q    <= omask_d;
      ost_q      <= ost_d;
      intr_ovf_q <= |(reg_t'(ost_q) & omask_q);
      for (int i = 0; i < N_COUNTERS; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef PMU_QUOTA_EN
  reg_t                qmask_q, qlim_q, qacc_q, qacc_d;
  reg_t                pc_w;
  logic [REG_WIDTH:0]  qsum_w;
  logic                intr_q_q;
  logic                unused_q;

  always_comb begin
    pc_w = '0;
    for (int i = 0; i < N_COUNTERS; i++)
      pc_w = pc_w + reg_t'(events_i[i] & qmask_q[i]);
  end

  assign qsum_w = {1'b0, qacc_q} + {1'b0, pc_w};

  always_comb begin
    qacc_d = qacc_q;
    if (softrst_w)
      qacc_d = '0;
    else if (en_q)
      qacc_d = qsum_w[REG_WIDTH] ? '1
             : qsum_w[REG_WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      qmask_q  <= '0;
      qlim_q   <= '0;
      qacc_q   <= '0;
      intr_q_q <= 1'b0;
    end else begin
      if (wr_w && didx_q == I_QMASK) qmask_q <= hwdata_i;
      if (wr_w && didx_q == I_QLIM)  qlim_q  <= hwdata_i;
      qacc_q   <= qacc_d;
      intr_q_q <= (qlim_q != '0) && (qacc_q >= qlim_q);
    end
  end

  assign intr_quota_o = intr_q_q;
  assign unused_q = ^qmask_q[REG_WIDTH-1:N_COUNTERS];
`else
  assign intr_quota_o = 1'b0;
`endif

  always_comb begin
    rdata_w = '0;
    if (rd_w) begin
      unique case (1'b1)
        (didx_q == '0):
          rdata_w = reg_t'(en_q);
        (didx_q != '0 && didx_q <= 32'(N_COUNTERS)):
          rdata_w = cnt_q[csel_w[CW-1:0]];
        (didx_q == I_OMASK):
          rdata_w = omask_q;
        (didx_q == I_OST):
          rdata_w = reg_t'(ost_q);
`ifdef PMU_QUOTA_EN
        (didx_q == I_QMASK):
          rdata_w = qmask_q;
        (didx_q == I_QLIM):
          rdata_w = qlim_q;
        (didx_q == I_QACC):
          rdata_w = qacc_q;
`endif
        default:
          rdata_w = '0;
      endcase
    end
  end

  assign hrdata_o        = rdata_w;
  assign hreadyo_o       = 1'b1;
  assign hresp_o         = 2'b00;
  assign intr_overflow_o = intr_ovf_q;
  assign intr_MCCU_o     = 1'b0;
  assign intr_RDC_o      = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{hsize_i, hburst_i, hprot_i,
                       hmastlock_i, htrans_i[0],
                       events_i[N_SOC_EV-1:N_COUNTERS],
                       csel_w[31:CW], I_QACC, I_QMASK,
                       I_QLIM};

endmodule

// File: tb/tb_pmu_ahb_slave.sv
// Directed bench for pmu_ahb_slave: bus access, counters, overflow, quota.
// Define PMU_QUOTA_EN for both RTL and bench to cover quota accounting.
module tb_pmu_ahb_slave;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        hsel = 1'b0;
  logic        hready = 1'b1;
  logic [31:0] haddr_s = '0;
  logic        hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b010;
  logic [2:0]  hburst = 3'b000;
  logic [31:0] hwdata = '0;
  logic [3:0]  hprot = 4'h0;
  logic        hlock = 1'b0;
  logic        hreadyo;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [31:0] events = '0;
  logic        i_ovf, i_quota, i_mccu, i_rdc;

  int vectors = 0;
  int miscompares = 0;

  pmu_ahb_slave dut (
    .clk_i(clk), .rstn_i(rstn),
    .hsel_i(hsel), .hreadyi_i(hready),
    .haddr_i(haddr_s), .hwrite_i(hwrite),
    .htrans_i(htrans), .hsize_i(hsize),
    .hburst_i(hburst), .hwdata_i(hwdata),
    .hprot_i(hprot), .hmastlock_i(hlock),
    .hreadyo_o(hreadyo), .hresp_o(hresp),
    .hrdata_o(hrdata), .events_i(events),
    .intr_overflow_o(i_ovf),
    .intr_quota_o(i_quota),
    .intr_MCCU_o(i_mccu),
    .intr_RDC_o(i_rdc)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ra(input int n);
    return 32'h80100000 + 32'(n * 4);
  endfunction

  task automatic ahb_write(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [31:0] ev);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10;
    hwrite = 1'b1; haddr_s = a;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    hwdata = d; events = ev;
    @(posedge clk); #1;
    events = '0;
  endtask

  task automatic ahb_read(input logic [31:0] a,
                          output logic [31:0] d);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10;
    hwrite = 1'b0; haddr_s = a;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    d = hrdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [38:0] obs;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {hreadyo, hresp, hrdata, i_ovf, i_quota, i_mccu, i_rdc};
    vectors++;
    if (obs !== {1'b1, 2'b00, 32'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h",
               obs, {1'b1, 2'b00, 32'h0, 4'h0});
    end
    rstn = 1'b1;
    ahb_read(ra(0), d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_cfg: got %h want 0", d);
    end
    ahb_read(ra(1), d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_cnt0: got %h want 0", d);
    end
    vectors++;
    if ({hreadyo, hresp} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_resp: got %b want 100",
               {hreadyo, hresp});
    end
  endtask

  task automatic test_regmap();
    logic [31:0] d;
    ahb_write(32'h801000ac, 32'hcafecafe, '0);
    ahb_read(32'h801000ac, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL reserved43: got %h want 0", d);
    end
    ahb_write(ra(25), 32'h12345678, '0);
    ahb_read(ra(25), d);
    vectors++;
    if (d !== 32'h12345678) begin
      miscompares++;
      $display("FAIL ovf_mask_rw: got %h want 12345678", d);
    end
    ahb_write(ra(47), 32'h55aa55aa, '0);
    ahb_read(ra(47), d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL idx47: got %h want 0", d);
    end
    ahb_write(ra(46), 32'h0000ffff, '0);
    ahb_read(ra(46), d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL reserved46: got %h want 0", d);
    end
  endtask

  task automatic test_counting();
    logic [31:0] d;
    ahb_write(ra(0), 32'h1, '0);
    events = 32'h00000003;
    repeat (50) @(posedge clk);
    #1 events = '0;
    ahb_read(ra(1), d);
    vectors++;
    if (d !== 32'd50) begin
      miscompares++;
      $display("FAIL cnt0_50: got %0d want 50", d);
    end
    ahb_read(ra(2), d);
    vectors++;
    if (d !== 32'd50) begin
      miscompares++;
      $display("FAIL cnt1_50: got %0d want 50", d);
    end
    ahb_read(ra(3), d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL cnt2_0: got %0d want 0", d);
    end
    ahb_write(ra(0), 32'h2, '0);
    ahb_read(ra(1), d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL softrst_cnt0: got %0d want 0", d);
    end
    ahb_read(ra(2), d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL softrst_cnt1: got %0d want 0", d);
    end
    ahb_read(ra(0), d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL softrst_cfg: got %h want 0", d);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    ahb_write(ra(1), 32'hffffffff, '0);
    ahb_write(ra(25), 32'h1, '0);
    ahb_write(ra(0), 32'h1, '0);
    @(posedge clk); #1 events = 32'h1;
    @(posedge clk); #1 events = '0;
    @(posedge clk); #1;
    vectors++;
    if (i_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_irq_set: got %b want 1", i_ovf);
    end
    ahb_read(ra(1), d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL ovf_cnt0: got %h want 0", d);
    end
    ahb_read(ra(26), d);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL ovf_status: got %h want 1", d);
    end
    ahb_write(ra(26), 32'h1, '0);
    @(posedge clk); #1;
    vectors++;
    if (i_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_irq_clr: got %b want 0", i_ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    ahb_write(ra(1), 32'hffffffff, '0);
    ahb_write(ra(26), 32'h1, 32'h1);
    ahb_read(ra(26), d);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL w1c_vs_wrap: got %h want 1", d);
    end
    ahb_read(ra(1), d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_cnt0: got %h want 0", d);
    end
    ahb_write(ra(2), 32'h100, 32'h2);
    ahb_read(ra(2), d);
    vectors++;
    if (d !== 32'h100) begin
      miscompares++;
      $display("FAIL wr_priority: got %h want 100", d);
    end
    ahb_write(ra(26), 32'h1, '0);
  endtask

  task automatic test_disable();
    logic [31:0] d;
    ahb_write(ra(0), 32'h0, '0);
    events = 32'h3;
    repeat (5) @(posedge clk);
    #1 events = '0;
    ahb_read(ra(1), d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL dis_cnt0: got %h want 0", d);
    end
    ahb_read(ra(2), d);
    vectors++;
    if (d !== 32'h100) begin
      miscompares++;
      $display("FAIL dis_cnt1: got %h want 100", d);
    end
  endtask

  task automatic test_out_of_region();
    logic [31:0] d;
    ahb_write(32'h08010000, 32'h3, '0);
    ahb_read(ra(0), d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL oor_cfg: got %h want 0", d);
    end
    ahb_read(ra(2), d);
    vectors++;
    if (d !== 32'h100) begin
      miscompares++;
      $display("FAIL oor_cnt1: got %h want 100", d);
    end
    ahb_read(32'h08010000, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL oor_read: got %h want 0", d);
    end
    vectors++;
    if ({hreadyo, hresp} !== 3'b100) begin
      miscompares++;
      $display("FAIL oor_resp: got %b want 100",
               {hreadyo, hresp});
    end
  endtask

  task automatic test_quota();
    logic [31:0] d;
`ifdef PMU_QUOTA_EN
    ahb_write(ra(0), 32'h3, '0);
    ahb_write(ra(27), 32'hf, '0);
    ahb_write(ra(28), 32'h8, '0);
    events = 32'hf;
    repeat (2) @(posedge clk);
    #1 events = '0;
    ahb_read(ra(29), d);
    vectors++;
    if (d !== 32'h8) begin
      miscompares++;
      $display("FAIL quota_acc: got %h want 8", d);
    end
    vectors++;
    if (i_quota !== 1'b1) begin
      miscompares++;
      $display("FAIL quota_irq: got %b want 1", i_quota);
    end
    ahb_write(ra(0), 32'h0, '0);
`else
    ahb_write(ra(27), 32'hf, '0);
    ahb_read(ra(27), d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL quota_mask_rsv: got %h want 0", d);
    end
    vectors++;
    if (i_quota !== 1'b0) begin
      miscompares++;
      $display("FAIL quota_irq_off: got %b want 0", i_quota);
    end
`endif
    vectors++;
    if ({i_mccu, i_rdc} !== 2'b00) begin
      miscompares++;
      $display("FAIL mccu_rdc: got %b want 00", {i_mccu, i_rdc});
    end
  endtask

  initial begin
    test_reset();
    test_regmap();
    test_counting();
    test_overflow();
    test_back_to_back();
    test_disable();
    test_out_of_region();
    test_quota();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pmu_ahb_slave.md
PMU_AHB_SLAVE -- requirements
Module: pmu_ahb_slave

Interface
REQ-001 The block SHALL have one clock, clk_i, and a synchronous, active-low reset, rstn_i.
REQ-002 Parameters (name, default, meaning) SHALL be:
- haddr, 32'h80100000, base address.
- hmask, 32'hfff, address mask.
- REG_WIDTH, 32, register width.
- N_REGS, 47, register count.
- N_COUNTERS, 24, number of counters.
- N_SOC_EV, 32, event input width.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk_i, in, 1, clock.
- rstn_i, in, 1, reset.
- hsel_i, in, 1, slave select.
- hreadyi_i, in, 1, bus ready.
- haddr_i, in, 32, address.
- hwrite_i, in, 1, write.
- htrans_i, in, 2, transfer type.
- hsize_i, in, 3, ignored.
- hburst_i, in, 3, ignored.
- hwdata_i, in, 32, write data.
- hprot_i, in, 4, ignored.
- hmastlock_i, in, 1, ignored.
- hreadyo_o, out, 1, ready.
- hresp_o, out, 2, response.
- hrdata_o, out, 32, read data.
- events_i, in, N_SOC_EV, event pulses.
- intr_overflow_o, out, 1, overflow IRQ.
- intr_quota_o, out, 1, quota IRQ.
- intr_MCCU_o, out, 1, MCCU IRQ.
- intr_RDC_o, out, 1, RDC IRQ.

Function
REQ-004 The address phase SHALL be accepted at a rising edge when hsel_i=1, hreadyi_i=1 and htrans_i[1]=1; haddr_i and hwrite_i are latched at that edge.
REQ-005 An access SHALL be in-region when (haddr_i & ~hmask) == (haddr & ~hmask); index = (haddr_i & hmask)>>2.
REQ-006 Transfers SHALL be zero-wait: hreadyo_o=1 always, and hresp_o=2'b00 (OKAY) always, including for out-of-region or unmapped accesses.
REQ-007 Write data SHALL be taken from hwdata_i in the data phase (cycle after acceptance) and the register updated at the end of that cycle.
REQ-008 Read data SHALL drive hrdata_o during the data phase; reads that are out-of-region, reserved or index>=N_REGS SHALL return 0, and writes to them SHALL be ignored.
REQ-009 The register map SHALL be:
- 0: CFG RW; bit0 EN, bit1 SOFTRST (self-clearing, reads 0).
- 1..24: counter i-1, RW.
- 25: OVF_MASK, RW.
- 26: OVF_STATUS, write-1-to-clear.
- 27: QUOTA_MASK, RW.
- 28: QUOTA_LIMIT, RW.
- 29: QUOTA_ACC, RO.
- 30..46: reserved.
REQ-010 When EN=1, counter i SHALL increment by 1 in each cycle with events_i[i]=1 (i<24); events_i[31:24] SHALL be ignored.
REQ-011 A counter wrapping 0xFFFFFFFF->0 SHALL set OVF_STATUS[i]; a same-cycle wrap and W1C SHALL leave the bit set.
REQ-012 A bus write to a counter SHALL take priority over a same-cycle increment.
REQ-013 SOFTRST=1 written SHALL clear all counters, OVF_STATUS and QUOTA_ACC on the next edge; EN takes the written value.
REQ-014 intr_overflow_o SHALL be |(OVF_STATUS & OVF_MASK), registered (one cycle after the status change).
REQ-015 intr_MCCU_o and intr_RDC_o SHALL be constant 0.
REQ-016 Counters SHALL be unchanged while EN=0.

Reset
REQ-017 On rstn_i=0 at a clock edge, all registers, counters and QUOTA_ACC SHALL reset to 0; all interrupts SHALL reset to 0; hreadyo_o=1, hresp_o=0, hrdata_o=0; any pending data phase SHALL be dropped.

Configuration
REQ-018 With PMU_QUOTA_EN defined: when EN=1, QUOTA_ACC SHALL add popcount(events_i[23:0] & QUOTA_MASK[23:0]) each cycle, saturating at 0xFFFFFFFF.
REQ-019 With PMU_QUOTA_EN defined: intr_quota_o SHALL be registered (QUOTA_LIMIT!=0 && QUOTA_ACC>=QUOTA_LIMIT).
REQ-020 Without PMU_QUOTA_EN: registers 27-29 SHALL be reserved (read 0) and intr_quota_o SHALL be constant 0.

Verification
REQ-021 Reset, then read register 0 and counter 1 -> both read 0; hreadyo_o=1, hresp_o=0.
REQ-022 Write 0xcafecafe to 0x801000ac (index 43, reserved), then read it back -> returns 0; write 0x12345678 to index 25 -> reads back 0x12345678.
REQ-023 Write CFG=1, hold events_i=0x00000003 for 50 cycles -> counters 0 and 1 = 50, counter 2 = 0; write CFG=2 -> all counters 0.
REQ-024 Write counter 0 = 0xFFFFFFFF, OVF_MASK=1, EN=1, pulse events_i[0] -> counter 0 = 0, OVF_STATUS bit0=1, intr_overflow_o=1; write 1 to reg 26 -> intr_overflow_o=0.
REQ-025 With PMU_QUOTA_EN: QUOTA_MASK=0xF, QUOTA_LIMIT=8, events_i=0xF for 2 cycles -> QUOTA_ACC=8, intr_quota_o=1.
REQ-026 Write to 0x08010000 (out-of-region) -> no register changes, hresp_o=0.
